// File: rtl/stf_seq_gen.sv
// L-STF sample sequencer: walks the 16-entry STF ROM NUM_REP times and streams
// the registered samples downstream, halving the first sample when windowing is on.
module stf_seq_gen #(
  parameter int NUM_REP   = 10,
  parameter int WINDOW_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  output logic [3:0]  rom_addr,
  input  logic [31:0] rom_dout,
  output logic [31:0] out_iq,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [7:0] TOTAL    = 8'(16 * NUM_REP);
  localparam logic [7:0] LAST_IDX = 8'(16 * NUM_REP - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       accept;

  // Handshake: a sample transfers on any rising edge where out_valid and
  // out_ready are both high; out_iq/out_last never change while out_valid=1
  // and out_ready=0, and out_valid only drops after a transfer or an abort.
  assign accept   = out_valid & out_ready;

  // cnt always holds the index of the next sample to fetch, so the ROM
  // address is simply its low nibble and the period wrap is free.
  assign rom_addr = cnt[3:0];

  // Edge window: arithmetic halving of each signed 16-bit component,
  // which rounds toward minus infinity.
  function automatic logic [31:0] win(input logic [31:0] d);
    logic signed [15:0] i_h;
    logic signed [15:0] q_h;
    i_h = d[31:16];
    q_h = d[15:0];
    if (WINDOW_EN != 0) begin
      return {i_h >>> 1, q_h >>> 1};
    end
    return d;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      out_iq    <= 32'd0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        cnt       <= 8'd0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            cnt       <= 8'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            if (start) begin
              out_iq    <= win(rom_dout);
              out_valid <= 1'b1;
              // A burst is at least one full period, so sample 0 is never last.
              out_last  <= 1'b0;
              cnt       <= 8'd1;
              busy      <= 1'b1;
              state     <= RUN;
            end
          end
          RUN: begin
            busy <= 1'b1;
            if (accept) begin
              if (cnt == TOTAL) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                done      <= 1'b1;
                busy      <= 1'b0;
                cnt       <= 8'd0;
                state     <= IDLE;
              end else begin
                out_iq   <= rom_dout;
                out_last <= (cnt == LAST_IDX);
                cnt      <= cnt + 8'd1;
              end
            end
          end
          default: begin
            state     <= IDLE;
            cnt       <= 8'd0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stf_seq_gen.sv
// Directed bench for stf_seq_gen: a default instance (10 periods, windowed)
// and a short instance (2 periods, no window), each fed by a bench-side STF ROM.
module tb_stf_seq_gen;

  logic        clk;
  logic        rst;

  logic        a_start, a_abort, a_ready;
  logic [3:0]  a_addr;
  logic [31:0] a_dout, a_iq;
  logic        a_valid, a_last, a_busy, a_done;

  logic        b_start, b_abort, b_ready;
  logic [3:0]  b_addr;
  logic [31:0] b_dout, b_iq;
  logic        b_valid, b_last, b_busy, b_done;

  int n_checks;
  int n_errors;

  logic [31:0] rom_a [16];

  function automatic logic [31:0] stf_rom(input logic [3:0] a);
    case (a)
      4'd0:    return 32'h02f2_02f2;
      4'd1:    return 32'h03d9_0198;
      4'd2:    return 32'hff8a_fc27;
      4'd3:    return 32'hfbd6_0000;
      4'd4:    return 32'h05e3_0000;
      4'd5:    return 32'h0198_fc27;
      4'd6:    return 32'h0000_fbd6;
      4'd7:    return 32'hfc27_ff8a;
      4'd8:    return 32'hfd0e_fd0e;
      4'd9:    return 32'hff8a_03d9;
      4'd10:   return 32'hfbd6_1111;
      4'd11:   return 32'h0198_0198;
      4'd12:   return 32'h0000_05e3;
      4'd13:   return 32'hfc27_0198;
      4'd14:   return 32'hfe68_ff8a;
      default: return 32'h0198_03d9;
    endcase
  endfunction

  assign a_dout = rom_a[a_addr];
  assign b_dout = stf_rom(b_addr);

  stf_seq_gen dut_a (
    .clk(clk), .rst(rst), .start(a_start), .abort(a_abort),
    .rom_addr(a_addr), .rom_dout(a_dout), .out_iq(a_iq), .out_valid(a_valid),
    .out_ready(a_ready), .out_last(a_last), .busy(a_busy), .done(a_done)
  );

  stf_seq_gen #(.NUM_REP(2), .WINDOW_EN(0)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
    .rom_addr(b_addr), .rom_dout(b_dout), .out_iq(b_iq), .out_valid(b_valid),
    .out_ready(b_ready), .out_last(b_last), .busy(b_busy), .done(b_done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive a one-cycle start; returns at the negedge where sample 0 should show.
  task automatic pulse_start_a();
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  // Consume a full 160-sample burst on instance A, entered at the negedge
  // where sample 0 is presented. Optional 3-cycle stall at stall_idx, an
  // ignored start at restart_idx, and a start in the done cycle when chain=1.
  task automatic burst_a(input logic [31:0] first, input int stall_idx,
                         input int restart_idx, input bit chain, input string tag);
    int k;
    int stalls;
    int cyc;
    logic [31:0] exp;
    k = 0; stalls = 0; cyc = 0;
    while (k < 160 && cyc < 600) begin
      exp = (k == 0) ? first : rom_a[k % 16];
      chk($sformatf("%s valid[%0d]", tag, k), a_valid, 1);
      chk($sformatf("%s iq[%0d]", tag, k), a_iq, exp);
      chk($sformatf("%s last[%0d]", tag, k), a_last, (k == 159));
      chk($sformatf("%s busy[%0d]", tag, k), a_busy, 1);
      chk($sformatf("%s done[%0d]", tag, k), a_done, 0);
      a_start = (k == restart_idx);
      if (k == stall_idx && stalls < 3) begin
        a_ready = 1'b0;
        stalls++;
      end else begin
        a_ready = 1'b1;
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    a_start = 1'b0;
    a_ready = 1'b1;
    chk({tag, " end valid"}, a_valid, 0);
    chk({tag, " end done"}, a_done, 1);
    chk({tag, " end busy"}, a_busy, 0);
    chk({tag, " end last"}, a_last, 0);
    if (chain) begin
      a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
    end else begin
      @(negedge clk);
      chk({tag, " done pulse width"}, a_done, 0);
      chk({tag, " idle valid"}, a_valid, 0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 16; i++) rom_a[i] = stf_rom(4'(i));
    rst = 1'b1;
    a_start = 1'b0; a_abort = 1'b0; a_ready = 1'b1;
    b_start = 1'b0; b_abort = 1'b0; b_ready = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst a_iq", a_iq, 0);
    chk("rst a_valid", a_valid, 0);
    chk("rst a_last", a_last, 0);
    chk("rst a_busy", a_busy, 0);
    chk("rst a_done", a_done, 0);
    chk("rst a_addr", a_addr, 0);
    chk("rst b_iq", b_iq, 0);
    chk("rst b_valid", b_valid, 0);
    rst = 1'b0;
    @(negedge clk);

    // Default burst: windowed first sample, 160 samples, done on cycle 161
    pulse_start_a();
    chk("t1 cycle1 iq", a_iq, 32'h0179_0179);
    burst_a(32'h0179_0179, -1, -1, 1'b0, "t1");

    // Two-period, unwindowed instance
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    chk("t2 first iq", b_iq, 32'h02f2_02f2);
    for (int k = 0; k < 32; k++) begin
      chk($sformatf("t2 valid[%0d]", k), b_valid, 1);
      chk($sformatf("t2 iq[%0d]", k), b_iq, stf_rom(4'(k % 16)));
      chk($sformatf("t2 last[%0d]", k), b_last, (k == 31));
      chk($sformatf("t2 done[%0d]", k), b_done, 0);
      @(negedge clk);
    end
    chk("t2 end valid", b_valid, 0);
    chk("t2 end done", b_done, 1);
    chk("t2 end busy", b_busy, 0);
    @(negedge clk);
    chk("t2 done width", b_done, 0);

    // Backpressure on the address-5 sample
    pulse_start_a();
    burst_a(32'h0179_0179, 5, -1, 1'b0, "t3");

    // Abort while sample 40 is presented
    pulse_start_a();
    for (int k = 0; k < 40; k++) begin
      chk($sformatf("t4 iq[%0d]", k), a_iq, (k == 0) ? 32'h0179_0179 : rom_a[k % 16]);
      @(negedge clk);
    end
    chk("t4 sample40 iq", a_iq, rom_a[8]);
    a_abort = 1'b1;
    @(negedge clk);
    a_abort = 1'b0;
    chk("t4 abort valid", a_valid, 0);
    chk("t4 abort busy", a_busy, 0);
    chk("t4 abort last", a_last, 0);
    chk("t4 abort done", a_done, 0);
    chk("t4 abort addr", a_addr, 0);
    @(negedge clk);
    chk("t4 post done", a_done, 0);
    chk("t4 post valid", a_valid, 0);
    pulse_start_a();
    burst_a(32'h0179_0179, -1, -1, 1'b0, "t4r");

    // Start mid-burst is ignored; start in the done cycle chains a new burst
    pulse_start_a();
    burst_a(32'h0179_0179, -1, 50, 1'b1, "t5a");
    burst_a(32'h0179_0179, -1, -1, 1'b0, "t5b");

    // Window rounding on negative components
    rom_a[0] = 32'hfc27_8001;
    pulse_start_a();
    chk("win neg first", a_iq, 32'hfe13_c000);
    burst_a(32'hfe13_c000, -1, -1, 1'b0, "win");
    rom_a[0] = stf_rom(4'd0);

    // Reset at sample 100
    pulse_start_a();
    for (int k = 0; k < 100; k++) begin
      chk($sformatf("t6 iq[%0d]", k), a_iq, (k == 0) ? 32'h0179_0179 : rom_a[k % 16]);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6 rst iq", a_iq, 0);
    chk("t6 rst valid", a_valid, 0);
    chk("t6 rst last", a_last, 0);
    chk("t6 rst busy", a_busy, 0);
    chk("t6 rst done", a_done, 0);
    chk("t6 rst addr", a_addr, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("t6 no done[%0d]", k), a_done, 0);
    end

    // abort together with start in IDLE
    a_start = 1'b1;
    a_abort = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    a_abort = 1'b0;
    chk("t6 ab+st valid", a_valid, 0);
    chk("t6 ab+st busy", a_busy, 0);
    @(negedge clk);
    chk("t6 ab+st valid2", a_valid, 0);
    chk("t6 ab+st done", a_done, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stf_seq_gen.md
Name: stf_seq_gen

Overview:
- Sequencer that produces the 802.11 legacy short training field (L-STF) as a stream of I/Q samples.
- Sits directly upstream of the 16-entry STF sample ROM: it drives the ROM address and registers the combinational ROM data.
- Repeats the 16-sample period NUM_REP times and optionally applies the half-amplitude edge window to the very first sample.
- Output goes to the TX sample mux through a valid/ready handshake.

Parameters:
NUM_REP, 10, number of 16-sample STF periods per burst (range 1..15).
WINDOW_EN, 1, when 1, sample 0 of period 0 is halved; when 0, no windowing.

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request to emit one STF burst
abort  input  1  terminates the burst immediately
rom_addr  output  4  STF ROM address
rom_dout  input  32  STF ROM data, same cycle; [31:16]=I, [15:0]=Q, signed Q-format
out_iq  output  32  sample; [31:16]=I, [15:0]=Q
out_valid  output  1  out_iq holds a sample
out_ready  input  1  downstream accepts the sample
out_last  output  1  marks the final sample of the burst
busy  output  1  a burst is in progress
done  output  1  one-cycle pulse after the final sample is accepted

Behaviour:
- Reset (clk and rst are fixed as stated above): all outputs are 0, state=IDLE, cnt=0. Reset mid-burst discards the burst and produces no done.
- Constants and address:
  - TOTAL = 16*NUM_REP; cnt is 8 bits.
  - rom_addr = cnt[3:0], combinational from the registered cnt.
- Handshake:
  - A sample is accepted when out_valid & out_ready.
  - out_iq and out_last are held stable while out_valid=1 and out_ready=0.
- States: IDLE, RUN.
- IDLE:
  - busy=0, out_valid=0, cnt=0.
  - If start=1 and abort=0: load out_iq = win(rom_dout) (address 0), set out_valid=1, cnt=1, out_last=(TOTAL==1 never; NUM_REP>=1 gives TOTAL>=16), and go to RUN.
  - Latency: the first sample is valid the cycle after start.
- RUN:
  - busy=1.
  - On accept with cnt<TOTAL: load out_iq=rom_dout, cnt=cnt+1, out_last=(cnt==TOTAL-1).
  - On accept with cnt==TOTAL: out_valid=0, out_last=0, done=1 for one cycle, cnt=0, go to IDLE.
  - With no accept: hold all state.
- Window: win() applies only to the first sample of the burst when WINDOW_EN=1. It arithmetically shifts each signed 16-bit half right by 1 (rounds toward minus infinity). Every other sample passes unmodified.
- start while busy is ignored. start in the same cycle as done is accepted (the state is IDLE in that cycle).
- abort, from any state: next cycle out_valid=0, out_last=0, busy=0, cnt=0, state=IDLE, no done. abort together with start in IDLE: abort wins and no burst starts.
- Throughput: one sample per cycle with out_ready held high. No bubbles between periods; the 15->0 address wrap is seamless.

Test Plan:
1. Reset, then start at cycle 0 with out_ready=1 and defaults. Required response:
   - cycle 1: out_iq=0x0179_0179;
   - cycle 2: 0x03d9_0198;
   - cycle 17: 0x02f2_02f2;
   - cycle 160: 0x0198_03d9 with out_last=1;
   - cycle 161: out_valid=0, done=1, busy=0.
2. WINDOW_EN=0 -> the first sample is 0x02f2_02f2. Also check NUM_REP=2: out_last on the 32nd sample and done the cycle after.
3. Backpressure: drop out_ready for 3 cycles while the sample at address 5 is presented -> out_iq is held at 0x0198_fc27 with out_valid=1 and out_last=0. After resume, the next sample is 0x0000_fbd6 and the total count is still 160.
4. Abort at sample 40 -> next cycle out_valid=0, busy=0, and done is never asserted. A start 2 cycles later restarts with 0x0179_0179.
5. Assert start at cycle 50 of a burst -> it is ignored, exactly 160 samples are emitted, and one done pulse. A start in the done cycle begins a new burst with its first sample the following cycle.
6. Assert rst at sample 100 -> all outputs are 0 the next cycle. abort+start in the same IDLE cycle -> no burst.
